fetch_stage: RTL

- Instruction-fetch stage of the 5-stage pipelined core, directly upstream of the instruction memory.
- Owns the program counter and drives PCF to the memory; also drives the memory's active-high enable pin.
- Captures the returned 20-bit instruction and PC+1 into the IF/ID pipeline register for decode.
- Handles stall, flush and branch/jump redirect from the hazard unit and the execute stage.

---
 rtl/fetch_stage.sv | 88 ++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem drive, IF/ID register (optional FETCH_PERF_EN counters)
module fetch_stage #(
    parameter int                  ADDR_W    = 15,
    parameter int                  INSTR_W   = 20,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               PCSrcE,
    input  logic [ADDR_W-1:0]  PCTargetE,
    input  logic [INSTR_W-1:0] RD,
    output logic [ADDR_W-1:0]  PCF,
    output logic               imem_en,
    output logic [INSTR_W-1:0] InstrD,
    output logic [ADDR_W-1:0]  PCD,
    output logic [ADDR_W-1:0]  PCPlus1D
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count
`endif
);

    localparam logic [0:0] WARMUP = 1'b0;
    localparam logic [0:0] RUN    = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] pc_plus1;

    // Wraps modulo 2^ADDR_W; the carry is intentionally dropped.
    assign pc_plus1 = PCF + ADDR_W'(1);

    // The memory is usable in every cycle outside reset, including the warmup cycle.
    assign imem_en = ~reset;

    // WARMUP lasts exactly one clock after reset, then RUN until the next reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WARMUP;
        else       state <= RUN;
    end

    // Program counter: redirect beats stall, otherwise sequential fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PCF <= RESET_PC;
        end else if (state == RUN) begin
            if (PCSrcE)       PCF <= PCTargetE;
            else if (!StallF) PCF <= pc_plus1;
        end
    end

    // IF/ID register: bubble during warmup, flush beats stall, otherwise capture RD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus1D <= '0;
        end else if (state == WARMUP || FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus1D <= '0;
        end else if (!StallD) begin
            InstrD   <= RD;
            PCD      <= PCF;
            PCPlus1D <= pc_plus1;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counters of useful fetches and front-end stall cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else if (state == RUN) begin
            if (!FlushD && !StallD && fetch_count != 32'hFFFF_FFFF)
                fetch_count <= fetch_count + 32'd1;
            if (StallF && !PCSrcE && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
